// File: rtl/reg_writeback_unit_pkg.sv
// reg_writeback_unit_pkg: shared register-file widths, load-queue depth and write-source encoding
package reg_writeback_unit_pkg;
  localparam int DEF_REG_COUNT    = 16;
  localparam int DEF_REG_SIZE     = 8;
  localparam int DEF_REG_PTR_SIZE = 4;
  localparam int DEF_LQ_DEPTH     = 4;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_BUF, SRC_RESP} wb_src_e;
endpackage

// File: rtl/reg_writeback_unit_ptr_fifo.sv
// ptr_fifo: circular FIFO of register pointers with occupancy count
module ptr_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int W = DEF_REG_PTR_SIZE,
  parameter int DEPTH = DEF_LQ_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign w_push = i_push & (o_count != CW'(DEPTH));
  assign w_pop = i_pop & (o_count != '0);
  assign o_head = r_mem[r_rd];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk)
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
      o_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      o_count <= o_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: merges ALU results and in-order load responses into one registered
// register-file write, tracking outstanding load destinations for decode hazard stalls
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int REG_SIZE = DEF_REG_SIZE,
  parameter int REG_PTR_SIZE = DEF_REG_PTR_SIZE,
  parameter int LQ_DEPTH = DEF_LQ_DEPTH,
  localparam int CW = $clog2(LQ_DEPTH) + 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [REG_PTR_SIZE-1:0] alu_dst,
  input  logic [REG_SIZE-1:0]     alu_data,
  input  logic                    ld_issue,
  input  logic [REG_PTR_SIZE-1:0] ld_issue_dst,
  output logic                    ld_issue_ready,
  input  logic                    mem_resp_valid,
  input  logic [REG_SIZE-1:0]     mem_resp_data,
  output logic                    mem_resp_ready,
  input  logic [REG_PTR_SIZE-1:0] dec_src_0,
  input  logic [REG_PTR_SIZE-1:0] dec_src_1,
  input  logic [REG_PTR_SIZE-1:0] dec_dst,
  input  logic                    dec_dst_valid,
  output logic                    D_stall,
  output logic                    W_we,
  output logic [REG_PTR_SIZE-1:0] W_dst,
  output logic [REG_SIZE-1:0]     W_result,
  output logic [CW-1:0]           pending_count
);
  logic [REG_COUNT-1:0] r_pending;
  logic r_buf_valid;
  logic [REG_SIZE-1:0] r_buf_data;
  logic [REG_PTR_SIZE-1:0] w_head;
  logic w_push, w_resp, w_retire;
  wb_src_e w_src;
  assign ld_issue_ready = pending_count != CW'(LQ_DEPTH);
  assign mem_resp_ready = !r_buf_valid;
  assign w_push = ld_issue & ld_issue_ready;
  // responses with no outstanding load or an occupied buffer are dropped
  assign w_resp = mem_resp_valid & (pending_count != '0) & !r_buf_valid;
  always_comb w_src = alu_valid ? SRC_ALU : r_buf_valid ? SRC_BUF : w_resp ? SRC_RESP : SRC_NONE;
  assign w_retire = (w_src == SRC_BUF) || (w_src == SRC_RESP);
  assign D_stall = r_pending[dec_src_0] | r_pending[dec_src_1] | (dec_dst_valid & r_pending[dec_dst]);
  ptr_fifo #(.W(REG_PTR_SIZE), .DEPTH(LQ_DEPTH)) u_lq (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_pop(w_retire),
    .i_din(ld_issue_dst),
    .o_head(w_head),
    .o_count(pending_count)
  );
  // a same-cycle set of the retiring index survives because the set is OR-ed last
  always_ff @(posedge clk)
    if (!reset) begin
      r_pending <= '0;
      r_buf_valid <= 1'b0;
      r_buf_data <= '0;
      W_we <= 1'b0;
      W_dst <= '0;
      W_result <= '0;
    end else begin
      r_pending <= (r_pending & ~(w_retire ? REG_COUNT'(1) << w_head : '0))
                 | (w_push ? REG_COUNT'(1) << ld_issue_dst : '0);
      r_buf_valid <= alu_valid & (r_buf_valid | w_resp);
      if (alu_valid & w_resp) r_buf_data <= mem_resp_data;
      W_we <= w_src != SRC_NONE;
      W_dst <= alu_valid ? alu_dst : w_head;
      W_result <= alu_valid ? alu_data : r_buf_valid ? r_buf_data : mem_resp_data;
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed and random stimulus against a queue-based reference model
module tb_reg_writeback_unit;
  logic clk = 0, reset = 0;
  logic alu_valid = 0, ld_issue = 0, mem_resp_valid = 0, dec_dst_valid = 0;
  logic [3:0] alu_dst = 0, ld_issue_dst = 0, dec_src_0 = 0, dec_src_1 = 0, dec_dst = 0;
  logic [7:0] alu_data = 0, mem_resp_data = 0;
  logic ld_issue_ready, mem_resp_ready, D_stall, W_we;
  logic [3:0] W_dst;
  logic [7:0] W_result;
  logic [2:0] pending_count;
  int errors = 0, checks = 0;
  int mq[$];
  logic [15:0] mpend = 0;
  logic mbuf_v = 0;
  logic [7:0] mbuf_d = 0;

  reg_writeback_unit dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst), .ld_issue_ready(ld_issue_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready),
    .dec_src_0(dec_src_0), .dec_src_1(dec_src_1), .dec_dst(dec_dst), .dec_dst_valid(dec_dst_valid),
    .D_stall(D_stall), .W_we(W_we), .W_dst(W_dst), .W_result(W_result),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; ld_issue = 0; mem_resp_valid = 0;
  endtask

  // one clock: check combinational outputs, advance the model, check the registered write
  task automatic step();
    bit acc, rok, ew;
    int h;
    logic [3:0] ed;
    logic [7:0] er;
    #1;
    check("ld_issue_ready", ld_issue_ready, mq.size() != 4);
    check("mem_resp_ready", mem_resp_ready, !mbuf_v);
    check("pending_count", pending_count, mq.size());
    check("D_stall", D_stall, mpend[dec_src_0] | mpend[dec_src_1] | (dec_dst_valid & mpend[dec_dst]));
    acc = ld_issue && mq.size() < 4;
    rok = mem_resp_valid && mq.size() > 0 && !mbuf_v;
    ew = 0; ed = 0; er = 0;
    if (alu_valid) begin
      ew = 1; ed = alu_dst; er = alu_data;
      if (rok) begin mbuf_v = 1; mbuf_d = mem_resp_data; end
    end else if (mbuf_v || rok) begin
      h = mq.pop_front();
      ew = 1; ed = 4'(h); er = mbuf_v ? mbuf_d : mem_resp_data;
      mpend[h] = 0; mbuf_v = 0;
    end
    if (acc) begin mq.push_back(int'(ld_issue_dst)); mpend[ld_issue_dst] = 1; end
    @(posedge clk); #1;
    check("W_we", W_we, ew);
    if (ew) begin
      check("W_dst", W_dst, ed);
      check("W_result", W_result, er);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst W_we", W_we, 0);
    check("rst W_dst", W_dst, 0);
    check("rst W_result", W_result, 0);
    check("rst ld_issue_ready", ld_issue_ready, 1);
    check("rst mem_resp_ready", mem_resp_ready, 1);
    check("rst pending_count", pending_count, 0);
    mq.delete(); mpend = 0; mbuf_v = 0;
    check("rst D_stall", D_stall, 0);
    @(negedge clk);
    reset = 1;
    idle();
  endtask

  initial begin
    dec_src_0 = 0; dec_src_1 = 0; dec_dst = 0;
    do_reset();
    // ALU only
    alu_valid = 1; alu_dst = 3; alu_data = 8'hA5; step(); idle();
    // load RAW on r5
    ld_issue = 1; ld_issue_dst = 5; step(); idle();
    dec_src_0 = 5; step(); step();
    mem_resp_valid = 1; mem_resp_data = 8'h3C; step(); idle();
    step();
    dec_src_0 = 0;
    // ALU/response collision
    ld_issue = 1; ld_issue_dst = 2; step(); idle();
    alu_valid = 1; alu_dst = 1; alu_data = 8'h11;
    mem_resp_valid = 1; mem_resp_data = 8'h22; step(); idle();
    step(); step();
    // full queue
    for (int i = 4; i < 8; i++) begin ld_issue = 1; ld_issue_dst = 4'(i); step(); end
    ld_issue_dst = 9; step(); idle();
    dec_src_1 = 9; step(); dec_src_1 = 0;
    for (int i = 0; i < 4; i++) begin mem_resp_valid = 1; mem_resp_data = 8'(8'h40 + i); step(); end
    idle(); step();
    // WAW on r6
    ld_issue = 1; ld_issue_dst = 6; step(); idle();
    dec_dst = 6; dec_dst_valid = 1; step();
    dec_dst_valid = 0; step();
    // reset mid-traffic, then a late response
    alu_valid = 1; alu_dst = 7; alu_data = 8'h77; ld_issue = 1; ld_issue_dst = 8;
    do_reset();
    mem_resp_valid = 1; mem_resp_data = 8'h55; step(); idle(); step();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      alu_valid = $urandom_range(0, 2) == 0;
      alu_dst = 4'($urandom); alu_data = 8'($urandom);
      ld_issue = $urandom_range(0, 1) == 1;
      ld_issue_dst = 4'($urandom);
      mem_resp_valid = $urandom_range(0, 2) != 0;
      mem_resp_data = 8'($urandom);
      dec_src_0 = 4'($urandom); dec_src_1 = 4'($urandom);
      dec_dst = 4'($urandom); dec_dst_valid = 1'($urandom);
      step();
    end
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Single-write-port producer for the core register file: merges single-cycle ALU results with variable-latency, in-order memory load responses into one registered write (`W_result`/`W_dst`/`W_we`). Keeps a per-register pending scoreboard for outstanding loads and raises a decode stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file write port; decode reads `D_stall`.

## Interface
Parameters:
- `REG_COUNT`, `` `REG_COUNT `` (16): number of architectural registers.
- `REG_SIZE`, `` `REG_SIZE `` (8): data width.
- `REG_PTR_SIZE`, `` `REG_PTR_SIZE `` (4): register index width.
- `LQ_DEPTH`, 4: maximum outstanding loads; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; `reset==0` at a posedge clears all state.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_dst` in `REG_PTR_SIZE`: ALU destination register.
- `alu_data` in `REG_SIZE`: ALU result.
- `ld_issue` in 1: load issued to memory this cycle; reserves `ld_issue_dst`.
- `ld_issue_dst` in `REG_PTR_SIZE`: load destination register.
- `ld_issue_ready` out 1: load queue not full.
- `mem_resp_valid` in 1: in-order load response.
- `mem_resp_data` in `REG_SIZE`: load data.
- `mem_resp_ready` out 1: response buffer empty.
- `dec_src_0`, `dec_src_1` in `REG_PTR_SIZE`: decode source registers.
- `dec_dst` in `REG_PTR_SIZE`, `dec_dst_valid` in 1: decode destination.
- `D_stall` out 1: hazard; decode must hold.
- `W_we` out 1, `W_dst` out `REG_PTR_SIZE`, `W_result` out `REG_SIZE`: registered write to the register file.
- `pending_count` out `$clog2(LQ_DEPTH)+1`: outstanding loads.

## Operation
- Load queue: circular FIFO of destination pointers, depth `LQ_DEPTH`; `ld_issue` pushes, a load retire pops. `ld_issue_ready = (pending_count != LQ_DEPTH)`; `ld_issue` while not ready is ignored (no push, no scoreboard set).
- Response buffer: 1 entry (data). A `mem_resp_valid` that loses arbitration is captured there; `mem_resp_ready = !buf_valid`. A response arriving while `buf_valid` is a protocol violation and is dropped.
- Write arbitration, one write per cycle, priority: ALU > buffered load > direct response. A load is retired when written: its destination is popped from the queue head; `pending[head_dst]` is cleared.
- Scoreboard: `pending[REG_COUNT]`. Set on accepted `ld_issue`, cleared on retire; same-cycle set and clear of the same index → set wins.
- `D_stall = pending[dec_src_0] | pending[dec_src_1] | (dec_dst_valid & pending[dec_dst])`, combinational from current state.
- A response with an empty queue is ignored.

## Timing
- Reset values: `W_we=0`, `W_dst=0`, `W_result=0`, queue empty, `pending=0`, `buf_valid=0`; thus `ld_issue_ready=1`, `mem_resp_ready=1`, `D_stall=0`, `pending_count=0`.
- ALU result → `W_*` at the next posedge (1-cycle latency). Direct response → 1 cycle; if it collided with the ALU, 2 cycles (buffered).
- `pending` clears at the same edge on which `W_we` asserts for that load; the register file commits one edge later, so decode needs the register-file bypass or one additional stall cycle (owner: decode).
- `ld_issue` and retire in the same cycle at full: the pop frees a slot only next cycle; `ld_issue_ready` is based on the registered count.
- `pending_count` wraps never; saturates at `LQ_DEPTH` by construction.
- Reset mid-operation: all outstanding loads are forgotten; late responses after reset are ignored (queue empty).

## Structure
- Shared constants package/header (`Inc/Constants.vh`): `REG_COUNT`, `REG_SIZE`, `REG_PTR_SIZE`, and new `LQ_DEPTH` default.
- One sub-module: `ptr_fifo` (parameterised width/depth circular FIFO with push/pop/count) for the load queue.

## Test plan
- Reset: hold `reset=0` 2 cycles mid-traffic → all outputs at reset values; a response with `mem_resp_data=8'h55` afterwards → no write.
- ALU only: `alu_valid`, `alu_dst=3`, `alu_data=8'hA5` → next cycle `W_we=1`, `W_dst=3`, `W_result=8'hA5`.
- Load RAW: `ld_issue` dst=5; decode `dec_src_0=5` → `D_stall=1` until response `8'h3C` is written (`W_dst=5`), then `D_stall=0`.
- Collision: ALU (dst=1, `8'h11`) and response (dst=2, `8'h22`) same cycle → cycle+1 writes r1, cycle+2 writes r2; `mem_resp_ready=0` for one cycle.
- Full queue: issue 4 loads (dst 4,5,6,7) → `ld_issue_ready=0`, fifth issue ignored; responses retire in order 4,5,6,7; `pending_count` 4→0.
- WAW: load pending on r6, `dec_dst=6`, `dec_dst_valid=1` → `D_stall=1`.
